i2c_codec_responder: RTL and testbench

- I2C target (slave) model of the audio codec control port. It receives the 3-byte write frames that the codec-setup I2C master issues: device address, then a 16-bit word made of a 7-bit register index and 9-bit data.
- ACKs matching frames and stores the data into an internal register file. The register file is readable by the bench and the top-level loopback logic.
- Sits on the same resolved SCLK/SDAT wires as the master. Used for on-chip self-check and simulation.

---
 rtl/i2c_codec_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_responder.sv
// I2C write-only target for the audio codec control port.
// Accepts addr + 16-bit {idx,data} frames and keeps a 9-bit register file.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         NUM_REGS    = 16,
  parameter logic [6:0] RESET_IDX   = 7'h0F,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_sdat,
  output logic       o_sdat,
  output logic       o_oen,
  output logic       o_reg_we,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_frame_err,
  output logic       o_busy,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_BYTE1,
    S_ACK_1,
    S_BYTE2,
    S_ACK_2,
    S_WAIT_STOP,
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES:0] scl_pipe_q;
  logic [SYNC_STAGES:0] sda_pipe_q;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] b1_q, b1_d;
  logic       oen_q, oen_d;
  logic       we_q, we_d;
  logic [6:0] waddr_q, waddr_d;
  logic [8:0] wdata_q, wdata_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       pend_q, pend_d;
  logic [8:0] regs_q [NUM_REGS];
  logic [8:0] regs_d [NUM_REGS];

  logic scl, scl_p, sda, sda_p;
  logic ev_start, ev_stop, ev_rise, ev_fall;
  logic addr_hit, truncated;
  logic [6:0] w_idx;
  logic [8:0] w_dat;

  // Top bit of each pipe is the history flop for edge detection
  assign scl   = scl_pipe_q[SYNC_STAGES-1];
  assign scl_p = scl_pipe_q[SYNC_STAGES];
  assign sda   = sda_pipe_q[SYNC_STAGES-1];
  assign sda_p = sda_pipe_q[SYNC_STAGES];

  assign ev_start = scl & scl_p & sda_p & ~sda;
  assign ev_stop  = scl & scl_p & ~sda_p & sda;
  assign ev_rise  = scl & ~scl_p;
  assign ev_fall  = ~scl & scl_p;

  assign addr_hit = (sr_q[7:1] == DEV_ADDR) & ~sr_q[0];
  assign w_idx    = b1_q[7:1];
  assign w_dat    = {b1_q[0], sr_q};

  always_comb begin
    truncated = 1'b0;
    case (state_q)
      S_ADDR, S_ACK_A, S_BYTE1,
      S_ACK_1, S_BYTE2, S_ACK_2: truncated = 1'b1;
      default:                   truncated = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    b1_d    = b1_q;
    oen_d   = oen_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    busy_d  = busy_q;
    pend_d  = pend_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    if (ev_start || ev_stop) begin
      oen_d  = 1'b0;
      pend_d = 1'b0;
      cnt_d  = 4'd0;
      err_d  = truncated;
      if (ev_stop) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end else begin
        state_d = S_ADDR;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (ev_rise && cnt_q < 4'd8) begin
            sr_d  = {sr_q[6:0], sda};
            cnt_d = cnt_q + 4'd1;
          end else if (ev_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == S_ADDR) begin
              state_d = S_ACK_A;
              oen_d   = addr_hit;
            end else if (state_q == S_BYTE1) begin
              state_d = S_ACK_1;
              oen_d   = 1'b1;
              b1_d    = sr_q;
            end else begin
              state_d = S_ACK_2;
              oen_d   = 1'b1;
            end
          end
        end
        S_ACK_A, S_ACK_1, S_ACK_2: begin
          if (ev_rise) begin
            cnt_d = 4'd9;
          end else if (ev_fall && cnt_q == 4'd9) begin
            cnt_d = 4'd0;
            oen_d = 1'b0;
            if (state_q == S_ACK_A) begin
              state_d = addr_hit ? S_BYTE1 : S_IGNORE;
            end else if (state_q == S_ACK_1) begin
              state_d = S_BYTE2;
            end else begin
              state_d = S_WAIT_STOP;
              pend_d  = 1'b0;
              we_d    = 1'b1;
              waddr_d = w_idx;
              wdata_d = w_dat;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (w_idx == RESET_IDX && w_dat == 9'd0) begin
                  regs_d[i] = 9'd0;
                end else if (32'(w_idx) == i) begin
                  regs_d[i] = w_dat;
                end
              end
            end
          end
        end
        // A STOP is always preceded by one SCL rise; a fall after it is an extra bit
        S_WAIT_STOP: begin
          if (ev_rise) begin
            pend_d = 1'b1;
          end else if (ev_fall && pend_q) begin
            pend_d  = 1'b0;
            err_d   = 1'b1;
            state_d = S_IGNORE;
          end
        end
        S_IGNORE: oen_d = 1'b0;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_pipe_q <= '1;
      sda_pipe_q <= '1;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      sr_q       <= 8'd0;
      b1_q       <= 8'd0;
      oen_q      <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= 7'd0;
      wdata_q    <= 9'd0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 9'd0;
      end
    end else begin
      scl_pipe_q <= {scl_pipe_q[SYNC_STAGES-1:0], i_sclk};
      sda_pipe_q <= {sda_pipe_q[SYNC_STAGES-1:0], i_sdat};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      b1_q       <= b1_d;
      oen_q      <= oen_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    o_rd_data = 9'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(i_rd_addr) == i) begin
        o_rd_data = regs_q[i];
      end
    end
  end

  assign o_sdat      = 1'b0;
  assign o_oen       = oen_q;
  assign o_reg_we    = we_q;
  assign o_reg_addr  = waddr_q;
  assign o_reg_data  = wdata_q;
  assign o_frame_err = err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench: bit-banged I2C master on an open-drain SDAT model.
module tb_i2c_codec_responder;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sdat;
  logic       o_sdat, o_oen, o_reg_we, o_frame_err, o_busy;
  logic [6:0] o_reg_addr;
  logic [8:0] o_reg_data;
  logic [3:0] rd_addr = 4'd0;
  logic [8:0] o_rd_data;

  int n_chk = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int err_cnt = 0;
  int ack_cnt = 0;
  logic [6:0] last_addr = 7'd0;
  logic [8:0] last_data = 9'd0;
  logic       acks [3];

  assign sdat = m_sda & (o_oen ? o_sdat : 1'b1);

  always #5 clk = ~clk;

  i2c_codec_responder dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sclk     (m_scl),
    .i_sdat     (sdat),
    .o_sdat     (o_sdat),
    .o_oen      (o_oen),
    .o_reg_we   (o_reg_we),
    .o_reg_addr (o_reg_addr),
    .o_reg_data (o_reg_data),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (o_rd_data)
  );

  always @(posedge clk) begin
    if (o_reg_we) begin
      we_cnt++;
      last_addr = o_reg_addr;
      last_data = o_reg_data;
    end
    if (o_frame_err) err_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    m_sda = 1'b0; wait_q(Q);
    m_scl = 1'b0; wait_q(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    m_sda = 1'b1; wait_q(Q);
  endtask

  task automatic send_bit(input logic v);
    m_sda = v;    wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wait_q(Q);
    m_scl = 1'b1; wait_q(Q / 2);
    ack = ~sdat;
    wait_q(Q - Q / 2);
    m_scl = 1'b0; wait_q(Q);
    if (ack) ack_cnt++;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input bit do_stop);
    logic k;
    bus_start();
    send_byte(a, k); acks[0] = k;
    send_byte(b, k); acks[1] = k;
    send_byte(c, k); acks[2] = k;
    if (do_stop) bus_stop();
  endtask

  task automatic rd(input logic [3:0] a, output logic [8:0] v);
    rd_addr = a;
    #1;
    v = o_rd_data;
  endtask

  logic [6:0] s_idx [10] = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4,
                             7'd5, 7'd6, 7'd7, 7'd8, 7'd9};
  logic [8:0] s_dat [10] = '{9'h017, 9'h117, 9'h079, 9'h079, 9'h012,
                             9'h1A5, 9'h002, 9'h042, 9'h019, 9'h001};

  initial begin
    logic [8:0] v;
    logic       k;
    int we0, err0, ack0;

    wait_q(3);
    check("rst_oen", o_oen, 0);
    check("rst_we", o_reg_we, 0);
    check("rst_addr", o_reg_addr, 0);
    check("rst_data", o_reg_data, 0);
    check("rst_err", o_frame_err, 0);
    check("rst_busy", o_busy, 0);
    rd(4'd4, v); check("rst_reg4", v, 0);
    rst_n = 1'b1;
    wait_q(4);

    // Matching write
    we0 = we_cnt; err0 = err_cnt;
    frame(8'h34, 8'h08, 8'h15, 1'b0);
    check("f1_busy", o_busy, 1);
    bus_stop();
    check("f1_ack0", acks[0], 1);
    check("f1_ack1", acks[1], 1);
    check("f1_ack2", acks[2], 1);
    check("f1_we", we_cnt - we0, 1);
    check("f1_addr", last_addr, 7'h04);
    check("f1_data", last_data, 9'h015);
    rd(4'd4, v); check("f1_reg4", v, 9'h015);
    check("f1_err", err_cnt - err0, 0);
    check("f1_busy_end", o_busy, 0);

    // Wrong address: no ACK, no write
    we0 = we_cnt; ack0 = ack_cnt;
    frame(8'h36, 8'h08, 8'h15, 1'b1);
    check("f2_acks", ack_cnt - ack0, 0);
    check("f2_we", we_cnt - we0, 0);
    rd(4'd4, v); check("f2_reg4", v, 9'h015);
    check("f2_busy", o_busy, 0);

    // Codec setup sequence
    we0 = we_cnt; ack0 = ack_cnt;
    for (int i = 0; i < 10; i++) begin
      frame(8'h34, {s_idx[i], s_dat[i][8]}, s_dat[i][7:0], 1'b1);
    end
    check("seq_we", we_cnt - we0, 10);
    check("seq_acks", ack_cnt - ack0, 30);
    for (int i = 0; i < 10; i++) begin
      rd(s_idx[i][3:0], v);
      check($sformatf("seq_reg%0d", i), v, s_dat[i]);
    end

    // Truncated frame
    we0 = we_cnt; err0 = err_cnt;
    bus_start();
    send_byte(8'h34, k);
    send_byte(8'h0E, k);
    bus_stop();
    check("tr_err", err_cnt - err0, 1);
    check("tr_we", we_cnt - we0, 0);
    rd(4'd7, v); check("tr_reg7", v, 9'h042);

    // Register-file clear
    frame(8'h34, 8'h08, 8'h15, 1'b1);
    rd(4'd4, v); check("clr_pre4", v, 9'h015);
    frame(8'h34, 8'h1E, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      check($sformatf("clr_reg%0d", i), v, 0);
    end

    // Extra fourth byte
    err0 = err_cnt; we0 = we_cnt;
    frame(8'h34, 8'h08, 8'h15, 1'b0);
    send_byte(8'hAA, k);
    check("x4_ack", k, 0);
    bus_stop();
    check("x4_err", err_cnt - err0, 1);
    check("x4_we", we_cnt - we0, 1);

    // Reset in BYTE1
    bus_start();
    send_byte(8'h34, k);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("mr_busy_pre", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mr_busy", o_busy, 0);
    check("mr_oen", o_oen, 0);
    check("mr_addr", o_reg_addr, 0);
    check("mr_data", o_reg_data, 0);
    rd(4'd4, v); check("mr_reg4", v, 0);
    m_scl = 1'b1; m_sda = 1'b1;
    wait_q(Q);
    rst_n = 1'b1;
    wait_q(Q);
    we0 = we_cnt;
    frame(8'h34, 8'h00, 8'h97, 1'b1);
    check("mr_we", we_cnt - we0, 1);
    check("mr_waddr", last_addr, 7'h00);
    rd(4'd0, v); check("mr_reg0", v, 9'h097);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
